// File: rtl/alu_arbiter_if.sv
// Request/response handshakes and shared-ALU bus
// between two requesters, the arbiter and the ALU.
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);
  logic              i_req0_valid;
  logic              i_req1_valid;
  logic              o_req0_ready;
  logic              o_req1_ready;
  logic [DATA_W-1:0] i_req0_a;
  logic [DATA_W-1:0] i_req1_a;
  logic [DATA_W-1:0] i_req0_b;
  logic [DATA_W-1:0] i_req1_b;
  logic [CTRL_W-1:0] i_req0_ctrl;
  logic [CTRL_W-1:0] i_req1_ctrl;
  logic [DATA_W-1:0] o_alu_a;
  logic [DATA_W-1:0] o_alu_b;
  logic [CTRL_W-1:0] o_alu_ctrl;
  logic [DATA_W-1:0] i_alu_result;
  logic              i_alu_zero;
  logic              o_rsp0_valid;
  logic              o_rsp1_valid;
  logic              i_rsp0_ready;
  logic              i_rsp1_ready;
  logic [DATA_W-1:0] o_rsp_result;
  logic              o_rsp_zero;
  logic              o_busy;

  modport slave (
    input  i_req0_valid, i_req1_valid,
    input  i_req0_a, i_req1_a,
    input  i_req0_b, i_req1_b,
    input  i_req0_ctrl, i_req1_ctrl,
    input  i_alu_result, i_alu_zero,
    input  i_rsp0_ready, i_rsp1_ready,
    output o_req0_ready, o_req1_ready,
    output o_alu_a, o_alu_b, o_alu_ctrl,
    output o_rsp0_valid, o_rsp1_valid,
    output o_rsp_result, o_rsp_zero,
    output o_busy
  );

  modport master (
    output i_req0_valid, i_req1_valid,
    output i_req0_a, i_req1_a,
    output i_req0_b, i_req1_b,
    output i_req0_ctrl, i_req1_ctrl,
    output i_alu_result, i_alu_zero,
    output i_rsp0_ready, i_rsp1_ready,
    input  o_req0_ready, o_req1_ready,
    input  o_alu_a, o_alu_b, o_alu_ctrl,
    input  o_rsp0_valid, o_rsp1_valid,
    input  o_rsp_result, o_rsp_zero,
    input  o_busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational
// ALU between two requesters, one operation in flight.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_owner;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_rsp0_valid;
  logic              r_rsp1_valid;

  logic              w_idle;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_rsp_done;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [CTRL_W-1:0] w_ctrl;

  assign w_idle = (r_state == IDLE);

  // Contention goes to whoever did not win last time.
  assign w_gnt0 = w_idle & bus.i_req0_valid
                & (~bus.i_req1_valid | r_last_grant);
  assign w_gnt1 = w_idle & bus.i_req1_valid
                & (~bus.i_req0_valid | ~r_last_grant);

  assign w_a    = w_gnt1 ? bus.i_req1_a    : bus.i_req0_a;
  assign w_b    = w_gnt1 ? bus.i_req1_b    : bus.i_req0_b;
  assign w_ctrl = w_gnt1 ? bus.i_req1_ctrl : bus.i_req0_ctrl;

  assign w_rsp_done = r_owner ? bus.i_rsp1_ready
                              : bus.i_rsp0_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_ctrl       <= '0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_a          <= w_a;
            r_b          <= w_b;
            r_ctrl       <= w_ctrl;
            r_owner      <= w_gnt1;
            r_last_grant <= w_gnt1;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          r_result     <= bus.i_alu_result;
          r_zero       <= bus.i_alu_zero;
          r_rsp0_valid <= ~r_owner;
          r_rsp1_valid <= r_owner;
          r_state      <= RESP;
        end
        RESP: begin
          if (w_rsp_done) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_req0_ready = w_gnt0;
  assign bus.o_req1_ready = w_gnt1;
  assign bus.o_alu_a      = r_a;
  assign bus.o_alu_b      = r_b;
  assign bus.o_alu_ctrl   = r_ctrl;
  assign bus.o_rsp0_valid = r_rsp0_valid;
  assign bus.o_rsp1_valid = r_rsp1_valid;
  assign bus.o_rsp_result = r_result;
  assign bus.o_rsp_zero   = r_zero;
  assign bus.o_busy       = ~w_idle;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed cases
// followed by randomized traffic with backpressure.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  alu_arbiter_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  alu_arbiter #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
  } op_t;

  typedef struct {
    int          own;
    logic [31:0] res;
    logic        z;
  } exp_t;

  op_t  src0[$];
  op_t  src1[$];
  exp_t sb[$];
  int   gorder[$];
  int   acc0 = 0;
  int   acc1 = 0;
  int   seen0 = 0;
  int   seen1 = 0;
  bit   rnd = 0;

  bit          tb_busy = 0;
  bit          tb_last = 1;
  int          tb_own = 0;
  int          tb_from = 0;
  logic [31:0] ea = '0;
  logic [31:0] eb = '0;
  logic [3:0]  ec = '0;

  function automatic logic [31:0] alu_f(
    logic [31:0] a, logic [31:0] b, logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic op_t mk(
    logic [31:0] a, logic [31:0] b, logic [3:0] c);
    op_t o;
    o.a = a;
    o.b = b;
    o.c = c;
    return o;
  endfunction

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Combinational ALU stand-in.
  always_comb begin
    bus.i_alu_result = alu_f(bus.o_alu_a, bus.o_alu_b,
                             bus.o_alu_ctrl);
    bus.i_alu_zero   = (alu_f(bus.o_alu_a, bus.o_alu_b,
                              bus.o_alu_ctrl) == 32'd0);
  end

  // Reference model of grants, busy window and response window.
  bit   er0, er1, rsp_on;
  int   win;
  exp_t ne;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      tb_busy = 0;
      tb_last = 1;
      sb.delete();
      ea = '0;
      eb = '0;
      ec = '0;
    end else begin
      er0 = 0;
      er1 = 0;
      win = 0;
      if (!tb_busy && (bus.i_req0_valid || bus.i_req1_valid)) begin
        if (bus.i_req0_valid && bus.i_req1_valid)
          win = tb_last ? 0 : 1;
        else
          win = bus.i_req1_valid ? 1 : 0;
        er0 = (win == 0);
        er1 = (win == 1);
      end
      rsp_on = tb_busy && (cyc >= tb_from);
      chk("req0_ready", bus.o_req0_ready, er0);
      chk("req1_ready", bus.o_req1_ready, er1);
      chk("busy", bus.o_busy, tb_busy);
      chk("rsp0_valid", bus.o_rsp0_valid, rsp_on && tb_own == 0);
      chk("rsp1_valid", bus.o_rsp1_valid, rsp_on && tb_own == 1);
      chk("alu_a", bus.o_alu_a, ea);
      chk("alu_b", bus.o_alu_b, eb);
      chk("alu_ctrl", bus.o_alu_ctrl, ec);
      if (rsp_on && (tb_own == 1 ? bus.i_rsp1_ready
                                 : bus.i_rsp0_ready))
        tb_busy = 0;
      if (er0 || er1) begin
        ea = win ? bus.i_req1_a : bus.i_req0_a;
        eb = win ? bus.i_req1_b : bus.i_req0_b;
        ec = win ? bus.i_req1_ctrl : bus.i_req0_ctrl;
        ne.own = win;
        ne.res = alu_f(ea, eb, ec);
        ne.z   = (ne.res == 32'd0);
        sb.push_back(ne);
        tb_busy = 1;
        tb_from = cyc + 2;
        tb_own  = win;
        tb_last = (win == 1);
        gorder.push_back(win);
        if (win == 1) acc1++;
        else acc0++;
      end
    end
  end

  task automatic pop_cmp(int who);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_unexpected: requester %0d got a response, none outstanding",
               who);
    end else begin
      e = sb.pop_front();
      chk("rsp_owner", who, e.own);
      chk("rsp_result", bus.o_rsp_result, e.res);
      chk("rsp_zero", bus.o_rsp_zero, e.z);
    end
  endtask

  // Response monitor: pops the scoreboard on each response handshake.
  bit          pv0 = 0;
  bit          pv1 = 0;
  logic [32:0] ph0;
  logic [32:0] ph1;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv0 = 0;
      pv1 = 0;
    end else begin
      if (bus.o_rsp0_valid) begin
        if (pv0)
          chk("rsp0_hold", {bus.o_rsp_zero, bus.o_rsp_result}, ph0);
        pv0 = 1;
        ph0 = {bus.o_rsp_zero, bus.o_rsp_result};
        if (bus.i_rsp0_ready) begin
          pv0 = 0;
          pop_cmp(0);
        end
      end else pv0 = 0;
      if (bus.o_rsp1_valid) begin
        if (pv1)
          chk("rsp1_hold", {bus.o_rsp_zero, bus.o_rsp_result}, ph1);
        pv1 = 1;
        ph1 = {bus.o_rsp_zero, bus.o_rsp_result};
        if (bus.i_rsp1_ready) begin
          pv1 = 0;
          pop_cmp(1);
        end
      end else pv1 = 0;
    end
  end

  task automatic tick();
    op_t o;
    @(posedge clk);
    #1;
    if (acc0 != seen0) begin
      seen0 = acc0;
      bus.i_req0_valid = 1'b0;
    end
    if (acc1 != seen1) begin
      seen1 = acc1;
      bus.i_req1_valid = 1'b0;
    end
    if (!bus.i_req0_valid && src0.size() > 0 &&
        (!rnd || $urandom_range(0, 2) != 0)) begin
      o = src0.pop_front();
      bus.i_req0_a     = o.a;
      bus.i_req0_b     = o.b;
      bus.i_req0_ctrl  = o.c;
      bus.i_req0_valid = 1'b1;
    end
    if (!bus.i_req1_valid && src1.size() > 0 &&
        (!rnd || $urandom_range(0, 2) != 0)) begin
      o = src1.pop_front();
      bus.i_req1_a     = o.a;
      bus.i_req1_b     = o.b;
      bus.i_req1_ctrl  = o.c;
      bus.i_req1_valid = 1'b1;
    end
    if (rnd) begin
      bus.i_rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.i_rsp1_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drain(int maxc);
    int n;
    n = 0;
    while ((src0.size() > 0 || src1.size() > 0 ||
            bus.i_req0_valid || bus.i_req1_valid || tb_busy) &&
           n < maxc) begin
      tick();
      n++;
    end
    chk("drain_in_time", (n < maxc), 1);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_req0_ready"}, bus.o_req0_ready, 0);
    chk({tag, "_req1_ready"}, bus.o_req1_ready, 0);
    chk({tag, "_rsp0_valid"}, bus.o_rsp0_valid, 0);
    chk({tag, "_rsp1_valid"}, bus.o_rsp1_valid, 0);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_alu_a"}, bus.o_alu_a, 0);
    chk({tag, "_alu_b"}, bus.o_alu_b, 0);
    chk({tag, "_alu_ctrl"}, bus.o_alu_ctrl, 0);
    chk({tag, "_result"}, bus.o_rsp_result, 0);
    chk({tag, "_zero"}, bus.o_rsp_zero, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          a0;
    int          a1;
    op_t         o;
    logic [3:0]  codes [6];
    codes[0] = 4'b0000;
    codes[1] = 4'b0001;
    codes[2] = 4'b0010;
    codes[3] = 4'b0110;
    codes[4] = 4'b0111;
    codes[5] = 4'b1100;

    rst_n = 1'b0;
    bus.i_req0_valid = 1'b0;
    bus.i_req1_valid = 1'b0;
    bus.i_req0_a = '0;
    bus.i_req0_b = '0;
    bus.i_req0_ctrl = '0;
    bus.i_req1_a = '0;
    bus.i_req1_b = '0;
    bus.i_req1_ctrl = '0;
    bus.i_rsp0_ready = 1'b1;
    bus.i_rsp1_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Simultaneous requests from reset: strict alternation.
    src0.push_back(mk(32'h0000F0F0, 32'h00000FF0, 4'b0000));
    src0.push_back(mk(32'h0000FF00, 32'h00000F0F, 4'b0000));
    src1.push_back(mk(32'd1, 32'd2, 4'b0001));
    src1.push_back(mk(32'd4, 32'd8, 4'b0001));
    gorder.delete();
    drain(100);
    chk("fair_count", gorder.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < gorder.size())
        chk("fair_order", gorder[i], i % 2);

    // Single ADD on requester 0.
    src0.push_back(mk(32'd5, 32'd7, 4'b0010));
    drain(50);
    chk("add_result_held", bus.o_rsp_result, 32'd12);
    chk("add_zero_held", bus.o_rsp_zero, 0);

    // SUB producing zero on requester 1.
    src1.push_back(mk(32'd9, 32'd9, 4'b0110));
    drain(50);
    chk("sub_result_held", bus.o_rsp_result, 32'd0);
    chk("sub_zero_held", bus.o_rsp_zero, 1);

    // Response backpressure with requester 1 waiting.
    bus.i_rsp0_ready = 1'b0;
    src0.push_back(mk(32'd100, 32'd23, 4'b0010));
    n = 0;
    while (!bus.o_rsp0_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp_rsp_seen", bus.o_rsp0_valid, 1);
    a1 = acc1;
    src1.push_back(mk(32'h0000_00FF, 32'h0000_0F00, 4'b1100));
    repeat (5) tick();
    chk("bp_no_accept", acc1, a1);
    chk("bp_busy", bus.o_busy, 1);
    chk("bp_valid_held", bus.o_rsp0_valid, 1);
    chk("bp_result_held", bus.o_rsp_result, 32'd123);
    bus.i_rsp0_ready = 1'b1;
    tick();
    chk("bp_not_same_cycle", acc1, a1);
    tick();
    chk("bp_next_cycle", acc1, a1 + 1);
    drain(50);

    // SLT with a negative operand; ALU inputs held in IDLE.
    src0.push_back(mk(32'hFFFF_FFFF, 32'd1, 4'b0111));
    drain(50);
    repeat (2) tick();
    chk("slt_alu_a_held", bus.o_alu_a, 32'hFFFF_FFFF);
    chk("slt_alu_b_held", bus.o_alu_b, 32'd1);
    chk("slt_alu_ctrl_held", bus.o_alu_ctrl, 4'b0111);
    chk("slt_result", bus.o_rsp_result, 32'd1);

    // Reset while in EXEC.
    a0 = acc0;
    src0.push_back(mk(32'd1, 32'd2, 4'b0010));
    n = 0;
    while (acc0 == a0 && n < 20) begin
      tick();
      n++;
    end
    chk("rst_exec_accepted", acc0, a0 + 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_exec");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    gorder.delete();
    src0.push_back(mk(32'd3, 32'd3, 4'b0110));
    src1.push_back(mk(32'd6, 32'd1, 4'b0111));
    drain(100);
    chk("rst_exec_grants", gorder.size(), 2);
    if (gorder.size() > 0)
      chk("rst_exec_first_grant", gorder[0], 0);

    // Randomized traffic with random backpressure.
    rnd = 1;
    for (int i = 0; i < 40; i++) begin
      o.c = codes[$urandom_range(0, 5)];
      o.a = $urandom;
      o.b = ($urandom_range(0, 3) == 0) ? o.a : $urandom;
      if ($urandom_range(0, 1) == 0) src0.push_back(o);
      else src1.push_back(o);
    end
    drain(3000);
    rnd = 0;
    bus.i_rsp0_ready = 1'b1;
    bus.i_rsp1_ready = 1'b1;
    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
